// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-ROM arbiter: ROM geometry, the
// grant-select encoding, the registered response record and two small
// helpers (address legality check, saturating wait-counter increment).
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int unsigned IMEM_DEPTH_WORDS = 2048;
  localparam int unsigned IMEM_BYTES       = IMEM_DEPTH_WORDS * 4;

  // Starvation counters are 4 bits and saturate at 15.
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_IF,
    SEL_LD
  } port_sel_e;

  // One registered response per requester port.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  // Misaligned or beyond the last ROM byte.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input int unsigned bytes);
    return (addr[1:0] != 2'b00) || (addr >= 32'(bytes));
  endfunction

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// -----------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the fetch (IF) and load (LD) request/response handshakes, the fetch
// flush and the ROM address/data pair. Member names keep the arbiter-side
// direction prefix (i_ = into the arbiter, o_ = out of the arbiter).
//   slave  : the arbiter
//   master : the requesters and the ROM (testbench side)
// -----------------------------------------------------------------------------
interface imem_arbiter_if;

  logic        i_if_req_valid;
  logic        o_if_req_ready;
  logic [31:0] i_if_addr;
  logic        o_if_rsp_valid;
  logic [31:0] o_if_rsp_data;
  logic        o_if_rsp_err;
  logic        i_flush;

  logic        i_ld_req_valid;
  logic        o_ld_req_ready;
  logic [31:0] i_ld_addr;
  logic        o_ld_rsp_valid;
  logic [31:0] o_ld_rsp_data;
  logic        o_ld_rsp_err;

  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_rdata;

  modport slave (
    input  i_if_req_valid, i_if_addr, i_flush,
    input  i_ld_req_valid, i_ld_addr,
    input  i_imem_rdata,
    output o_if_req_ready, o_if_rsp_valid, o_if_rsp_data, o_if_rsp_err,
    output o_ld_req_ready, o_ld_rsp_valid, o_ld_rsp_data, o_ld_rsp_err,
    output o_imem_addr
  );

  modport master (
    output i_if_req_valid, i_if_addr, i_flush,
    output i_ld_req_valid, i_ld_addr,
    output i_imem_rdata,
    input  o_if_req_ready, o_if_rsp_valid, o_if_rsp_data, o_if_rsp_err,
    input  o_ld_req_ready, o_ld_rsp_valid, o_ld_rsp_data, o_ld_rsp_err,
    input  o_imem_addr
  );

endinterface

// File: rtl/imem_rr_grant.sv
// -----------------------------------------------------------------------------
// imem_rr_grant
// Picks at most one requester per cycle. LD wins a conflict unless IF has
// been denied MAX_WAIT or more consecutive cycles, in which case IF wins
// (IF also wins when both ports are starved).
// Ports:
//   i_clk, i_reset  clock, asynchronous active-low reset
//   i_if_valid      fetch request valid
//   i_ld_valid      load request valid
//   o_sel           granted port (combinational)
// -----------------------------------------------------------------------------
module imem_rr_grant
  import imem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_if_valid,
  input  logic      i_ld_valid,
  output port_sel_e o_sel
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] if_wait_q, if_wait_d;
  logic [WAIT_W-1:0] ld_wait_q, ld_wait_d;
  logic              if_starved, ld_starved;

  assign if_starved = (if_wait_q >= LIMIT);
  assign ld_starved = (ld_wait_q >= LIMIT);

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    o_sel = SEL_NONE;
    if (i_if_valid && i_ld_valid) begin
      if (if_starved)      o_sel = SEL_IF;
      else if (ld_starved) o_sel = SEL_LD;
      else                 o_sel = SEL_LD;
    end else if (i_if_valid) begin
      o_sel = SEL_IF;
    end else if (i_ld_valid) begin
      o_sel = SEL_LD;
    end
  end

  // A counter only survives while its port keeps asking and keeps losing.
  always_comb begin
    if_wait_d = (i_if_valid && (o_sel != SEL_IF)) ? wait_inc(if_wait_q) : '0;
    ld_wait_d = (i_ld_valid && (o_sel != SEL_LD)) ? wait_inc(ld_wait_q) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, regardless of block order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      if_wait_q <= '0;
      ld_wait_q <= '0;
    end else begin
      if_wait_q <= if_wait_d;
      ld_wait_q <= ld_wait_d;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares one combinational-read instruction ROM between the fetch stage (IF)
// and the load/store unit (LD). One grant per cycle; the granted address goes
// to the ROM and the read word is registered into a one-cycle-latency
// response with an alignment/range error flag (data forced to 0 on error).
// i_flush masks the IF response in flight and suppresses the response of an
// IF grant made in the same cycle; LD is never affected by flush.
// Ports:
//   i_clk, i_reset   clock, asynchronous active-low reset
//   bus              imem_arbiter_if.slave (requests, responses, flush, ROM)
//   o_conflict_cnt   saturating count of cycles with both requests valid
// -----------------------------------------------------------------------------
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  imem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  localparam int unsigned       BYTES   = DEPTH_WORDS * 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  port_sel_e         sel;
  logic [31:0]       rom_addr;
  logic              grant_err;
  logic [31:0]       grant_data;

  logic [31:0]       last_addr_q, last_addr_d;
  rsp_t              if_rsp_q, if_rsp_d;
  rsp_t              ld_rsp_q, ld_rsp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  imem_rr_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_if_valid (bus.i_if_req_valid),
    .i_ld_valid (bus.i_ld_req_valid),
    .o_sel      (sel)
  );

  assign bus.o_if_req_ready = (sel == SEL_IF);
  assign bus.o_ld_req_ready = (sel == SEL_LD);

  // With no grant the ROM address parks on the last granted address.
  always_comb begin
    rom_addr = last_addr_q;
    case (sel)
      SEL_IF:  rom_addr = bus.i_if_addr;
      SEL_LD:  rom_addr = bus.i_ld_addr;
      default: rom_addr = last_addr_q;
    endcase
  end

  assign bus.o_imem_addr = rom_addr;
  assign grant_err       = addr_bad(rom_addr, BYTES);
  assign grant_data      = grant_err ? 32'h0 : bus.i_imem_rdata;
  assign last_addr_d     = (sel != SEL_NONE) ? rom_addr : last_addr_q;

  // Valid is a one-cycle pulse; data/err only change on a grant to the port.
  always_comb begin
    if_rsp_d       = if_rsp_q;
    if_rsp_d.valid = 1'b0;
    ld_rsp_d       = ld_rsp_q;
    ld_rsp_d.valid = 1'b0;
    if (sel == SEL_IF) begin
      if_rsp_d.valid = !bus.i_flush;
      if_rsp_d.err   = grant_err;
      if_rsp_d.data  = grant_data;
    end
    if (sel == SEL_LD) begin
      ld_rsp_d.valid = 1'b1;
      ld_rsp_d.err   = grant_err;
      ld_rsp_d.data  = grant_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_if_req_valid && bus.i_ld_req_valid && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      last_addr_q <= '0;
      if_rsp_q    <= '0;
      ld_rsp_q    <= '0;
      cnt_q       <= '0;
    end else begin
      last_addr_q <= last_addr_d;
      if_rsp_q    <= if_rsp_d;
      ld_rsp_q    <= ld_rsp_d;
      cnt_q       <= cnt_d;
    end
  end

  // A flush kills the fetch response already sitting in the register.
  assign bus.o_if_rsp_valid = if_rsp_q.valid & ~bus.i_flush;
  assign bus.o_if_rsp_data  = if_rsp_q.data;
  assign bus.o_if_rsp_err   = if_rsp_q.err;
  assign bus.o_ld_rsp_valid = ld_rsp_q.valid;
  assign bus.o_ld_rsp_data  = ld_rsp_q.data;
  assign bus.o_ld_rsp_err   = ld_rsp_q.err;
  assign o_conflict_cnt     = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter with a behavioural ROM and a response
// scoreboard: expected responses are queued when a grant is expected and
// popped when the response cycle comes round.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;
  import imem_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] conflict_cnt;

  imem_arbiter_if bus ();

  imem_arbiter #(
    .DEPTH_WORDS (2048),
    .MAX_WAIT    (4),
    .CNT_W       (16)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .bus            (bus),
    .o_conflict_cnt (conflict_cnt)
  );

  logic [31:0] rom [2048];
  assign bus.i_imem_rdata = rom[bus.o_imem_addr[12:2]];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad   = 0;
  exp_t        if_q[$];
  exp_t        ld_q[$];
  logic [31:0] last_addr;
  int          exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.err  = (a[1:0] != 2'b00) || (a >= 32'h0000_2000);
    e.data = e.err ? 32'h0 : rom[a[12:2]];
    return e;
  endfunction

  // Compares whatever response the previous edge produced against the queues.
  task automatic check_rsp(input bit fl);
    exp_t e;
    bit   exp_v;
    exp_v = (if_q.size() != 0) && !fl;
    check("if_rsp_valid", {31'b0, bus.o_if_rsp_valid}, {31'b0, exp_v});
    if (if_q.size() != 0) begin
      e = if_q.pop_front();
      if (exp_v && bus.o_if_rsp_valid) begin
        check("if_rsp_data", bus.o_if_rsp_data, e.data);
        check("if_rsp_err", {31'b0, bus.o_if_rsp_err}, {31'b0, e.err});
      end
    end
    exp_v = (ld_q.size() != 0);
    check("ld_rsp_valid", {31'b0, bus.o_ld_rsp_valid}, {31'b0, exp_v});
    if (ld_q.size() != 0) begin
      e = ld_q.pop_front();
      if (bus.o_ld_rsp_valid) begin
        check("ld_rsp_data", bus.o_ld_rsp_data, e.data);
        check("ld_rsp_err", {31'b0, bus.o_ld_rsp_err}, {31'b0, e.err});
      end
    end
  endtask

  // Entered at posedge+1; drives one cycle of stimulus, checks, returns at next posedge+1.
  task automatic cycle(input bit ifv, input logic [31:0] ifa,
                       input bit ldv, input logic [31:0] lda,
                       input bit fl, input port_sel_e es);
    logic [31:0] exp_addr;
    bus.i_if_req_valid = ifv;
    bus.i_if_addr      = ifa;
    bus.i_ld_req_valid = ldv;
    bus.i_ld_addr      = lda;
    bus.i_flush        = fl;
    #2;
    check_rsp(fl);
    check("if_req_ready", {31'b0, bus.o_if_req_ready}, {31'b0, es == SEL_IF});
    check("ld_req_ready", {31'b0, bus.o_ld_req_ready}, {31'b0, es == SEL_LD});
    exp_addr = (es == SEL_IF) ? ifa : (es == SEL_LD) ? lda : last_addr;
    check("imem_addr", bus.o_imem_addr, exp_addr);
    last_addr = exp_addr;
    check("conflict_cnt", {16'b0, conflict_cnt}, 32'(exp_cnt));
    if (es == SEL_IF && !fl) if_q.push_back(model(ifa));
    if (es == SEL_LD)        ld_q.push_back(model(lda));
    if (ifv && ldv && exp_cnt < 32'hFFFF) exp_cnt++;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input bit fl);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, fl, SEL_NONE);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 2048; i++) rom[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    rom[4] = 32'hDEAD_BEEF;

    bus.i_if_req_valid = 1'b0;
    bus.i_if_addr      = '0;
    bus.i_ld_req_valid = 1'b0;
    bus.i_ld_addr      = '0;
    bus.i_flush        = 1'b0;
    i_reset            = 1'b0;
    last_addr          = '0;
    exp_cnt            = 0;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_if_rsp_valid", {31'b0, bus.o_if_rsp_valid}, 32'h0);
    check("rst_ld_rsp_valid", {31'b0, bus.o_ld_rsp_valid}, 32'h0);
    check("rst_if_rsp_data", bus.o_if_rsp_data, 32'h0);
    check("rst_ld_rsp_data", bus.o_ld_rsp_data, 32'h0);
    check("rst_imem_addr", bus.o_imem_addr, 32'h0);
    check("rst_conflict_cnt", {16'b0, conflict_cnt}, 32'h0);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;

    // 1: IF only, word 4
    cycle(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, SEL_IF);
    idle(1'b0);

    // 2: six conflict cycles, IF wins once after four denials
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 32'h20, 1'b1, 32'h40, 1'b0, (k == 4) ? SEL_IF : SEL_LD);
    idle(1'b0);
    check("conflict_cnt_6", {16'b0, conflict_cnt}, 32'd6);

    // 3: error checks and range boundary
    cycle(1'b0, 32'h0, 1'b1, 32'h2000, 1'b0, SEL_LD);
    cycle(1'b0, 32'h0, 1'b1, 32'h0006, 1'b0, SEL_LD);
    cycle(1'b1, 32'h1FFC, 1'b0, 32'h0, 1'b0, SEL_IF);
    cycle(1'b1, 32'h0003, 1'b0, 32'h0, 1'b0, SEL_IF);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, SEL_IF);
    idle(1'b0);

    // 4: flush in grant cycle, flush in response cycle, LD unaffected
    cycle(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, SEL_IF);
    idle(1'b0);
    cycle(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, SEL_IF);
    idle(1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h18, 1'b1, SEL_LD);
    idle(1'b1);
    cycle(1'b1, 32'h20, 1'b1, 32'h24, 1'b1, SEL_LD);
    idle(1'b0);
    idle(1'b0);

    // 5: reset while a response is valid
    cycle(1'b1, 32'h30, 1'b0, 32'h0, 1'b0, SEL_IF);
    bus.i_if_req_valid = 1'b0;
    #1;
    e = if_q.pop_front();
    check("pre_reset_valid", {31'b0, bus.o_if_rsp_valid}, 32'h1);
    check("pre_reset_data", bus.o_if_rsp_data, e.data);
    i_reset = 1'b0;
    #1;
    check("reset_if_rsp_valid", {31'b0, bus.o_if_rsp_valid}, 32'h0);
    check("reset_ld_rsp_valid", {31'b0, bus.o_ld_rsp_valid}, 32'h0);
    last_addr = '0;
    exp_cnt   = 0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    idle(1'b0);
    check("post_reset_imem_addr", bus.o_imem_addr, 32'h0);

    // 6: conflict counter saturation
    bus.i_if_req_valid = 1'b1;
    bus.i_if_addr      = 32'h40;
    bus.i_ld_req_valid = 1'b1;
    bus.i_ld_addr      = 32'h44;
    bus.i_flush        = 1'b0;
    repeat (65539) @(posedge i_clk);
    #1;
    bus.i_if_req_valid = 1'b0;
    bus.i_ld_req_valid = 1'b0;
    #1;
    check("conflict_cnt_sat", {16'b0, conflict_cnt}, 32'h0000_FFFF);
    exp_cnt = 32'hFFFF;
    @(posedge i_clk);
    #1;
    cycle(1'b0, 32'h0, 1'b1, 32'h8, 1'b0, SEL_LD);
    cycle(1'b1, 32'h10, 1'b1, 32'h14, 1'b0, SEL_LD);
    idle(1'b0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
